// File: rtl/cpu_controller_if.sv
// Handshake and datapath-control bundle between the instruction source/datapath and cpu_controller.
// The controller connects through the slave modport; the instruction/datapath side uses master.
interface cpu_controller_if;
   logic        start;
   logic [15:0] instr;
   logic [2:0]  w_addr;
   logic [2:0]  r_addr;
   logic        w_en;
   logic        en_A;
   logic        en_B;
   logic        en_C;
   logic        en_status;
   logic        sel_A;
   logic        sel_B;
   logic [1:0]  wb_sel;
   logic [1:0]  shift_op;
   logic [1:0]  ALU_op;
   logic [15:0] sximm8;
   logic [15:0] sximm5;
   logic        waiting;
   logic        done;

   modport master (
      output start, instr,
      input  w_addr, r_addr, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
      input  wb_sel, shift_op, ALU_op, sximm8, sximm5, waiting, done
   );

   modport slave (
      input  start, instr,
      output w_addr, r_addr, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
      output wb_sel, shift_op, ALU_op, sximm8, sximm5, waiting, done
   );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle instruction controller: latches an instruction into IR and sequences the register
// file / ALU datapath through decode, operand fetch, execute and writeback with registered outputs.
module cpu_controller (
   input  logic             clk,
   input  logic             rst_n,
   cpu_controller_if.slave  bus
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WRITE_IMM,
      S_WRITE_REG
   } state_t;

   state_t      state_q;
   logic [15:0] ir_q;
   logic [2:0]  w_addr_q;
   logic [2:0]  r_addr_q;
   logic        w_en_q;
   logic        en_a_q;
   logic        en_b_q;
   logic        en_c_q;
   logic        en_status_q;
   logic        sel_a_q;
   logic [1:0]  wb_sel_q;
   logic [1:0]  shift_op_q;
   logic [1:0]  alu_op_q;
   logic        waiting_q;
   logic        done_q;

   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [2:0]  rn;
   logic [2:0]  rd;
   logic [1:0]  sh;
   logic [2:0]  rm;
   logic        is_alu;
   logic        is_mov_imm;
   logic        is_mov_reg;
   logic        is_mvn;
   logic        is_two_src;
   logic        is_cmp;

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign sh     = ir_q[4:3];
   assign rm     = ir_q[2:0];

   assign is_alu     = (opcode == 3'b101);
   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_mvn     = is_alu && (op == 2'b11);
   assign is_two_src = is_alu && (op != 2'b11);
   assign is_cmp     = is_alu && (op == 2'b01);

   // Every output register is loaded with the value belonging to the state being entered,
   // so outputs stay Moore while coming straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_WAIT;
         ir_q        <= 16'h0000;
         w_addr_q    <= 3'd0;
         r_addr_q    <= 3'd0;
         w_en_q      <= 1'b0;
         en_a_q      <= 1'b0;
         en_b_q      <= 1'b0;
         en_c_q      <= 1'b0;
         en_status_q <= 1'b0;
         sel_a_q     <= 1'b0;
         wb_sel_q    <= 2'b00;
         shift_op_q  <= 2'b00;
         alu_op_q    <= 2'b00;
         waiting_q   <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         w_addr_q    <= 3'd0;
         r_addr_q    <= 3'd0;
         w_en_q      <= 1'b0;
         en_a_q      <= 1'b0;
         en_b_q      <= 1'b0;
         en_c_q      <= 1'b0;
         en_status_q <= 1'b0;
         sel_a_q     <= 1'b0;
         wb_sel_q    <= 2'b00;
         shift_op_q  <= 2'b00;
         alu_op_q    <= 2'b00;
         waiting_q   <= 1'b0;
         done_q      <= 1'b0;

         case (state_q)
            S_WAIT: begin
               if (bus.start) begin
                  ir_q    <= bus.instr;
                  state_q <= S_DECODE;
               end else begin
                  waiting_q <= 1'b1;
               end
            end

            S_DECODE: begin
               if (is_mov_imm) begin
                  state_q  <= S_WRITE_IMM;
                  w_en_q   <= 1'b1;
                  w_addr_q <= rn;
                  wb_sel_q <= 2'b10;
               end else if (is_mov_reg || is_mvn) begin
                  state_q  <= S_GET_B;
                  r_addr_q <= rm;
                  en_b_q   <= 1'b1;
               end else if (is_two_src) begin
                  state_q  <= S_GET_A;
                  r_addr_q <= rn;
                  en_a_q   <= 1'b1;
               end else begin
                  // Undefined encodings return straight to WAIT without touching the datapath.
                  state_q   <= S_WAIT;
                  waiting_q <= 1'b1;
                  done_q    <= 1'b1;
               end
            end

            S_GET_A: begin
               state_q  <= S_GET_B;
               r_addr_q <= rm;
               en_b_q   <= 1'b1;
            end

            S_GET_B: begin
               state_q     <= S_EXEC;
               shift_op_q  <= sh;
               sel_a_q     <= is_two_src;
               alu_op_q    <= is_alu ? op : 2'b00;
               en_status_q <= is_cmp;
               en_c_q      <= !is_cmp;
            end

            S_EXEC: begin
               if (is_cmp) begin
                  state_q   <= S_WAIT;
                  waiting_q <= 1'b1;
                  done_q    <= 1'b1;
               end else begin
                  state_q  <= S_WRITE_REG;
                  w_en_q   <= 1'b1;
                  w_addr_q <= rd;
                  wb_sel_q <= 2'b00;
               end
            end

            S_WRITE_IMM, S_WRITE_REG: begin
               state_q   <= S_WAIT;
               waiting_q <= 1'b1;
               done_q    <= 1'b1;
            end

            default: begin
               state_q   <= S_WAIT;
               waiting_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.w_addr    = w_addr_q;
   assign bus.r_addr    = r_addr_q;
   assign bus.w_en      = w_en_q;
   assign bus.en_A      = en_a_q;
   assign bus.en_B      = en_b_q;
   assign bus.en_C      = en_c_q;
   assign bus.en_status = en_status_q;
   assign bus.sel_A     = sel_a_q;
   assign bus.sel_B     = 1'b0;
   assign bus.wb_sel    = wb_sel_q;
   assign bus.shift_op  = shift_op_q;
   assign bus.ALU_op    = alu_op_q;
   assign bus.waiting   = waiting_q;
   assign bus.done      = done_q;
   assign bus.sximm8    = {{8{ir_q[7]}}, ir_q[7:0]};
   assign bus.sximm5    = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: expected per-cycle output vectors are queued when an
// instruction is driven and popped/compared on each falling edge.
module tb_cpu_controller;

   typedef struct packed {
      logic        waiting;
      logic        done;
      logic        w_en;
      logic        en_A;
      logic        en_B;
      logic        en_C;
      logic        en_status;
      logic        sel_A;
      logic        sel_B;
      logic [2:0]  w_addr;
      logic [2:0]  r_addr;
      logic [1:0]  wb_sel;
      logic [1:0]  shift_op;
      logic [1:0]  alu_op;
      logic [15:0] sximm8;
      logic [15:0] sximm5;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t sb[$];

   cpu_controller_if bus ();

   cpu_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t base_vec(input logic [15:0] ir);
      vec_t v;
      v        = '0;
      v.sximm8 = {{8{ir[7]}}, ir[7:0]};
      v.sximm5 = {{11{ir[4]}}, ir[4:0]};
      return v;
   endfunction

   function automatic vec_t observe();
      vec_t v;
      v.waiting   = bus.waiting;
      v.done      = bus.done;
      v.w_en      = bus.w_en;
      v.en_A      = bus.en_A;
      v.en_B      = bus.en_B;
      v.en_C      = bus.en_C;
      v.en_status = bus.en_status;
      v.sel_A     = bus.sel_A;
      v.sel_B     = bus.sel_B;
      v.w_addr    = bus.w_addr;
      v.r_addr    = bus.r_addr;
      v.wb_sel    = bus.wb_sel;
      v.shift_op  = bus.shift_op;
      v.alu_op    = bus.ALU_op;
      v.sximm8    = bus.sximm8;
      v.sximm5    = bus.sximm5;
      return v;
   endfunction

   // Expected cycle-by-cycle trace from the cycle after start is sampled up to the done cycle.
   task automatic push_trace(input logic [15:0] ir);
      logic [2:0] opc;
      logic [1:0] opf;
      vec_t       v;
      opc = ir[15:13];
      opf = ir[12:11];
      sb.push_back(base_vec(ir));
      if (opc == 3'b110 && opf == 2'b10) begin
         v = base_vec(ir); v.w_en = 1'b1; v.w_addr = ir[10:8]; v.wb_sel = 2'b10;
         sb.push_back(v);
      end else if ((opc == 3'b110 && opf == 2'b00) || (opc == 3'b101)) begin
         if (opc == 3'b101 && opf != 2'b11) begin
            v = base_vec(ir); v.r_addr = ir[10:8]; v.en_A = 1'b1;
            sb.push_back(v);
         end
         v = base_vec(ir); v.r_addr = ir[2:0]; v.en_B = 1'b1;
         sb.push_back(v);
         v = base_vec(ir);
         v.shift_op = ir[4:3];
         v.sel_A    = (opc == 3'b101 && opf != 2'b11);
         v.alu_op   = (opc == 3'b101) ? opf : 2'b00;
         if (opc == 3'b101 && opf == 2'b01) v.en_status = 1'b1;
         else v.en_C = 1'b1;
         sb.push_back(v);
         if (!(opc == 3'b101 && opf == 2'b01)) begin
            v = base_vec(ir); v.w_en = 1'b1; v.w_addr = ir[7:5]; v.wb_sel = 2'b00;
            sb.push_back(v);
         end
      end
      v = base_vec(ir); v.waiting = 1'b1; v.done = 1'b1;
      sb.push_back(v);
   endtask

   task automatic push_idle(input logic [15:0] ir, input int n);
      vec_t v;
      v = base_vec(ir);
      v.waiting = 1'b1;
      for (int i = 0; i < n; i++) sb.push_back(v);
   endtask

   task automatic check_n(input int n, input string tag);
      vec_t e;
      vec_t o;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total++;
         if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed=%h required=expected entry", tag, observe());
         end else begin
            e = sb.pop_front();
            o = observe();
            assert (o === e) else begin
               bad++;
               $error("FAIL %s cyc%0d: observed=%h required=%h", tag, i, o, e);
            end
         end
      end
   endtask

   task automatic check_now(input vec_t e, input string tag);
      vec_t o;
      o = observe();
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: observed=%h required=%h", tag, o, e);
      end
   endtask

   task automatic run_single(input logic [15:0] ir, input string tag);
      int n;
      push_trace(ir);
      n = sb.size();
      bus.start = 1'b1;
      bus.instr = ir;
      check_n(1, tag);
      bus.start = 1'b0;
      bus.instr = 16'h0000;
      check_n(n - 1, tag);
      push_idle(ir, 1);
      check_n(1, {tag, "_idle"});
      $display("instr %h (%s) checked, latency %0d", ir, tag, n);
   endtask

   initial begin
      vec_t rv;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.instr = 16'h0000;

      // Reset state
      rv = base_vec(16'h0000);
      rv.waiting = 1'b1;
      @(negedge clk);
      check_now(rv, "reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      push_idle(16'h0000, 2);
      check_n(2, "post_reset_idle");

      // Single instructions of every class
      run_single(16'hD3FB, "mov_imm");
      run_single(16'hA148, "add");
      run_single(16'hAD06, "cmp");
      run_single(16'hC0F4, "mov_reg");
      run_single(16'hB822, "mvn");
      run_single(16'hB39A, "and");
      run_single(16'hE000, "undef_111");
      run_single(16'hC800, "undef_110_01");

      // start held with a new word while ADD runs: must be ignored
      push_trace(16'hA148);
      bus.start = 1'b1;
      bus.instr = 16'hA148;
      check_n(1, "ignore_start");
      bus.instr = 16'hD0FF;
      check_n(4, "ignore_start");
      bus.start = 1'b0;
      check_n(1, "ignore_start_done");
      push_idle(16'hA148, 2);
      check_n(2, "ignore_start_idle");
      $display("instr a148 with ignored start checked");

      // Back-to-back: MOV imm then CMP with start held high
      push_trace(16'hD3FB);
      push_trace(16'hAD06);
      bus.start = 1'b1;
      bus.instr = 16'hD3FB;
      check_n(1, "b2b");
      bus.instr = 16'hAD06;
      check_n(3, "b2b");
      bus.start = 1'b0;
      check_n(4, "b2b");
      push_idle(16'hAD06, 1);
      check_n(1, "b2b_idle");
      $display("back-to-back d3fb/ad06 checked");

      // Reset during EXEC of ADD aborts before writeback
      push_trace(16'hA148);
      bus.start = 1'b1;
      bus.instr = 16'hA148;
      check_n(1, "abort");
      bus.start = 1'b0;
      check_n(3, "abort");
      sb.delete();
      rst_n = 1'b0;
      #1;
      check_now(rv, "abort_async_reset");
      @(negedge clk);
      check_now(rv, "abort_reset_hold");
      rst_n = 1'b1;
      push_idle(16'h0000, 3);
      check_n(3, "abort_no_write");
      $display("reset abort of a148 checked");

      run_single(16'hA148, "add_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  in  1  request to execute instr; sampled only in WAIT.
REQ-004 SHALL have port instr  in  16  instruction word, captured into IR on accepted start.
REQ-005 SHALL have ports w_addr/r_addr  out  3 each  register-file write/read index.
REQ-006 SHALL have ports w_en, en_A, en_B, en_C, en_status, sel_A, sel_B  out  1 each  datapath enables/selects.
REQ-007 SHALL have ports wb_sel, shift_op, ALU_op  out  2 each  writeback source, shift, ALU operation.
REQ-008 SHALL have ports sximm8, sximm5  out  16 each  sign-extended IR[7:0], IR[4:0].
REQ-009 SHALL have ports waiting  out  1  (high in WAIT) and done  out  1  (one-cycle completion pulse).

Function
REQ-010 IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-011 sximm8={8{IR[7]},IR[7:0]}, sximm5={11{IR[4]},IR[4:0]}, driven continuously from IR.
REQ-012 States: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_IMM, WRITE_REG; one state per cycle.
REQ-013 WAIT: start=1 at edge -> IR<=instr, go DECODE; start=0 -> stay; start outside WAIT ignored, IR unchanged.
REQ-014 DECODE: 110/10 (MOV imm) -> WRITE_IMM; 110/00 (MOV reg) -> GET_B; 101/op 00,01,10 (ADD,CMP,AND) -> GET_A; 101/11 (MVN) -> GET_B; any other -> WAIT, no datapath effect.
REQ-015 GET_A: r_addr=Rn, en_A=1; -> GET_B.
REQ-016 GET_B: r_addr=Rm, en_B=1; -> EXEC.
REQ-017 EXEC: shift_op=sh, sel_B=0, sel_A=1 for ADD/CMP/AND else 0, ALU_op=op for opcode 101 else 00.
REQ-018 EXEC: CMP -> en_status=1, en_C=0, -> WAIT; all others -> en_C=1, en_status=0, -> WRITE_REG.
REQ-019 WRITE_REG: w_en=1, w_addr=Rd, wb_sel=00; -> WAIT.
REQ-020 WRITE_IMM: w_en=1, w_addr=Rn, wb_sel=10; -> WAIT.
REQ-021 Outputs not listed for a state SHALL be 0; outputs are Moore (state+IR only).
REQ-022 done SHALL be a registered pulse, high exactly the first cycle back in WAIT after any instruction (including undefined), else 0.
REQ-023 Latency start-sample to done: MOV imm 3, MOV reg/MVN 5, CMP 5, ADD/AND 6, undefined 2 cycles.
REQ-024 w_en SHALL be asserted at most once per instruction and never for CMP or undefined opcodes.
REQ-025 start high continuously SHALL begin next instruction in the done cycle (back-to-back, no bubble beyond WAIT).

Reset
REQ-026 rst_n=0 SHALL immediately force state=WAIT, IR=0, done=0, all enables/selects 0, waiting=1.
REQ-027 Reset mid-instruction SHALL abort it with no further w_en/en_C/en_status; first start after release executes normally.

Verification
REQ-028 Reset: rst_n=0 any state -> waiting=1, w_en=en_A=en_B=en_C=en_status=0, sximm8=0, done=0.
REQ-029 MOV R3,#-5 (0xD3FB) -> WRITE_IMM cycle: w_en=1, w_addr=3, wb_sel=10, sximm8=0xFFFB; done next cycle.
REQ-030 ADD R2,R1,R0 LSL1 (0xA148) -> r_addr=1/en_A, r_addr=0/en_B, EXEC shift_op=01 ALU_op=00 sel_A=1 en_C=1, WRITE_REG w_addr=2 w_en=1; done 6 cycles after start.
REQ-031 CMP R5,R6 (0xAD06) -> EXEC en_status=1, ALU_op=01, en_C=0; w_en never 1; done 5 cycles after start.
REQ-032 start=1 with 0xD0FF during ADD execution -> IR stays 0xA148, ADD completes unchanged, no extra instruction.
REQ-033 rst_n low during EXEC of 0xA148 -> WAIT immediately, WRITE_REG never entered, w_en stays 0.
